// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO and its burst reader: default widths and reader FSM states.
package fifo_pkg;

   localparam int unsigned FIFO_DATA_W = 8;
   localparam int unsigned FIFO_CNT_W  = 7;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StBurst = 2'd1,
      StDrain = 2'd2
   } rd_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order skid buffer; entry 0 is always the oldest word.
module skid_buf2
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W = FIFO_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic [1:0]        o_count
);

   logic [DATA_W-1:0] r_mem0;
   logic [DATA_W-1:0] r_mem1;
   logic [1:0]        r_count;
   logic              w_pop;
   logic              w_push;

   assign w_pop  = i_pop && (r_count != 2'd0);
   assign w_push = i_push && ((r_count != 2'd2) || w_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem0  <= '0;
         r_mem1  <= '0;
         r_count <= 2'd0;
      end else begin
         case ({w_push, w_pop})
            2'b10: begin
               if (r_count == 2'd0) r_mem0 <= i_data;
               else                 r_mem1 <= i_data;
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_mem0  <= r_mem1;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               // Simultaneous pop and push keeps occupancy; shift if two were held.
               if (r_count == 2'd1) begin
                  r_mem0 <= i_data;
               end else begin
                  r_mem0 <= r_mem1;
                  r_mem1 <= i_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_data  = r_mem0;
   assign o_valid = (r_count != 2'd0);
   assign o_count = r_count;

endmodule

// File: rtl/fifo_reader.sv
// Burst reader: pulls words from a FIFO in threshold- or flush-triggered bursts and streams them
// out through a 2-entry skid buffer with credit-based read issue.
module fifo_reader
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = FIFO_DATA_W,
   parameter int unsigned CNT_W     = FIFO_CNT_W,
   parameter int unsigned BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   output logic              fifo_rd_en,
   input  logic [DATA_W-1:0] fifo_data_out,
   input  logic              fifo_empty,
   input  logic [CNT_W-1:0]  fifo_counter,
   input  logic              flush,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic [15:0]       words_read
);

   localparam logic [CNT_W-1:0] LP_BURST_LEN = CNT_W'(BURST_LEN);

   rd_state_t         r_state;
   logic              r_flush_burst;
   logic              r_in_flight;
   logic [CNT_W-1:0]  r_issued;
   logic [15:0]       r_words_read;

   logic [DATA_W-1:0] w_buf_data;
   logic              w_buf_valid;
   logic [1:0]        w_buf_count;
   logic              w_pop;
   logic              w_rd;
   logic              w_quota_ok;
   logic [2:0]        w_credit;

   skid_buf2 #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_push  (r_in_flight),
      .i_data  (fifo_data_out),
      .i_pop   (w_pop),
      .o_data  (w_buf_data),
      .o_valid (w_buf_valid),
      .o_count (w_buf_count)
   );

   // Outputs are forced quiet during the reset cycle so nothing transfers or is requested.
   assign m_valid    = w_buf_valid && !rst;
   assign m_data     = rst ? '0 : w_buf_data;
   assign busy       = (r_state != StIdle) && !rst;
   assign words_read = r_words_read;

   assign w_pop      = m_valid && m_ready;
   assign w_credit   = {1'b0, w_buf_count} + {2'b00, r_in_flight} - {2'b00, w_pop};
   assign w_quota_ok = r_flush_burst || (r_issued < LP_BURST_LEN);
   assign w_rd       = (r_state == StBurst) && !rst && !fifo_empty && (w_credit <= 3'd1)
                       && w_quota_ok;
   assign fifo_rd_en = w_rd;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= StIdle;
         r_flush_burst <= 1'b0;
         r_in_flight   <= 1'b0;
         r_issued      <= '0;
         r_words_read  <= '0;
      end else begin
         r_in_flight <= w_rd;
         if (w_pop) r_words_read <= r_words_read + 16'd1;

         case (r_state)
            StIdle: begin
               if ((fifo_counter >= LP_BURST_LEN) || (flush && !fifo_empty)) begin
                  r_state       <= StBurst;
                  r_flush_burst <= flush;
                  r_issued      <= '0;
               end
            end
            StBurst: begin
               // Saturate so long flush bursts cannot wrap the count.
               if (w_rd && (r_issued != LP_BURST_LEN)) r_issued <= r_issued + CNT_W'(1);
               if (!r_flush_burst && w_rd && ((r_issued + CNT_W'(1)) == LP_BURST_LEN)) begin
                  r_state <= StDrain;
               end else if (fifo_empty && !w_rd) begin
                  r_state <= StDrain;
               end
            end
            StDrain: begin
               if ((w_buf_count == 2'd0) && !r_in_flight) r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a behavioural FIFO model and an output-stream monitor.
module tb_fifo_reader;

   localparam int DW       = 8;
   localparam int CW       = 7;
   localparam int STREAM_N = 65537;

   logic          clk = 1'b0;
   logic          rst;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_data_out = '0;
   logic          fifo_empty;
   logic [CW-1:0] fifo_counter;
   logic          flush;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          busy;
   logic [15:0]   words_read;

   always #5 clk = ~clk;

   fifo_reader #(
      .DATA_W    (DW),
      .CNT_W     (CW),
      .BURST_LEN (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_rd_en    (fifo_rd_en),
      .fifo_data_out (fifo_data_out),
      .fifo_empty    (fifo_empty),
      .fifo_counter  (fifo_counter),
      .flush         (flush),
      .m_data        (m_data),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .busy          (busy),
      .words_read    (words_read)
   );

   // FIFO model: initial block writes, posedge block reads.
   logic [7:0] mem [0:255];
   int   wr_ptr = 0;
   int   rd_ptr = 0;
   int   occ;
   int   stream_rd = 0;
   int   n_reads = 0;
   logic fifo_clr = 1'b0;
   logic cnt_ovr = 1'b0;
   logic stream = 1'b0;

   assign occ          = wr_ptr - rd_ptr;
   assign fifo_empty   = stream ? (stream_rd >= STREAM_N) : (occ == 0);
   assign fifo_counter = stream ? 7'd100 : (cnt_ovr ? 7'd4 : 7'(occ));

   always @(posedge clk) begin
      if (fifo_clr) begin
         rd_ptr <= wr_ptr;
      end else if (fifo_rd_en && !fifo_empty) begin
         n_reads <= n_reads + 1;
         if (stream) begin
            fifo_data_out <= 8'(stream_rd);
            stream_rd     <= stream_rd + 1;
         end else begin
            fifo_data_out <= mem[rd_ptr % 256];
            rd_ptr        <= rd_ptr + 1;
         end
      end
      if (!stream) stream_rd <= 0;
   end

   // Output monitor records transfers as they happen at the clock edge.
   logic [7:0] rx_mem [0:1023];
   int   rx_cyc [0:1023];
   int   rx_cnt = 0;
   int   cyc = 0;
   int   rd_empty_viol = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_valid && m_ready) begin
         rx_mem[rx_cnt % 1024] <= m_data;
         rx_cyc[rx_cnt % 1024] <= cyc;
         rx_cnt <= rx_cnt + 1;
      end
      if (fifo_rd_en && fifo_empty) rd_empty_viol <= rd_empty_viol + 1;
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      mem[wr_ptr % 256] = d;
      wr_ptr++;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      int rb;
      logic [7:0] exp1 [4];
      logic [7:0] exp2 [3];

      exp1 = '{8'd11, 8'd22, 8'd33, 8'd44};
      exp2 = '{8'd55, 8'd66, 8'd77};
      rst     = 1'b1;
      flush   = 1'b0;
      m_ready = 1'b1;

      // Reset state
      cycles(2);
      check_eq("rst_rd_en", fifo_rd_en, 0);
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_m_data", m_data, 0);
      check_eq("rst_busy", busy, 0);
      rst = 1'b0;
      cycles(1);
      check_eq("rst_words_read", words_read, 0);
      check_eq("rst_busy_after", busy, 0);

      // Threshold burst
      base = rx_cnt;
      rb   = n_reads;
      for (int i = 0; i < 4; i++) push(exp1[i]);
      cycles(12);
      check_eq("thr_reads", n_reads - rb, 4);
      check_eq("thr_rx_cnt", rx_cnt - base, 4);
      for (int i = 0; i < 4; i++) check_eq("thr_data", rx_mem[(base + i) % 1024], exp1[i]);
      check_eq("thr_consecutive", rx_cyc[(base + 3) % 1024] - rx_cyc[base % 1024], 3);
      check_eq("thr_busy", busy, 0);
      check_eq("thr_words_read", words_read, 4);

      // Below threshold, then flush
      base = rx_cnt;
      rb   = n_reads;
      for (int i = 0; i < 3; i++) push(exp2[i]);
      for (int i = 0; i < 6; i++) begin
         cycles(1);
         check_eq("low_rd_en", fifo_rd_en, 0);
         check_eq("low_busy", busy, 0);
      end
      flush = 1'b1;
      cycles(1);
      flush = 1'b0;
      check_eq("flush_busy", busy, 1);
      cycles(10);
      check_eq("flush_rx_cnt", rx_cnt - base, 3);
      for (int i = 0; i < 3; i++) check_eq("flush_data", rx_mem[(base + i) % 1024], exp2[i]);
      check_eq("flush_busy_end", busy, 0);
      check_eq("flush_words_read", words_read, 7);

      // Backpressure
      base    = rx_cnt;
      rb      = n_reads;
      m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
      for (int i = 0; i < 10; i++) begin
         cycles(1);
         if (i >= 4) begin
            check_eq("bp_hold_valid", m_valid, 1);
            check_eq("bp_hold_data", m_data, 8'h80);
         end
      end
      check_eq("bp_reads_le2", (n_reads - rb) <= 2, 1);
      check_eq("bp_no_xfer", rx_cnt - base, 0);
      m_ready = 1'b1;
      cycles(30);
      check_eq("bp_rx_cnt", rx_cnt - base, 8);
      for (int i = 0; i < 8; i++) check_eq("bp_data", rx_mem[(base + i) % 1024], 8'h80 + 8'(i));
      check_eq("bp_busy_end", busy, 0);
      check_eq("bp_words_read", words_read, 15);

      // Counter says 4 but FIFO empties after 2 reads
      base = rx_cnt;
      rb   = n_reads;
      push(8'hC0);
      push(8'hC1);
      cnt_ovr = 1'b1;
      cycles(1);
      cnt_ovr = 1'b0;
      check_eq("emp_busy", busy, 1);
      cycles(12);
      check_eq("emp_reads", n_reads - rb, 2);
      check_eq("emp_rx_cnt", rx_cnt - base, 2);
      check_eq("emp_data0", rx_mem[base % 1024], 8'hC0);
      check_eq("emp_data1", rx_mem[(base + 1) % 1024], 8'hC1);
      check_eq("emp_busy_end", busy, 0);
      check_eq("emp_words_read", words_read, 17);

      // Reset mid-burst after 2 words delivered
      base = rx_cnt;
      for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
      for (int i = 0; i < 20; i++) begin
         cycles(1);
         if (rx_cnt - base >= 2) break;
      end
      check_eq("mrst_reach2", rx_cnt - base, 2);
      rst = 1'b1;
      #1;
      check_eq("mrst_valid_in_rst", m_valid, 0);
      check_eq("mrst_busy_in_rst", busy, 0);
      check_eq("mrst_rd_en_in_rst", fifo_rd_en, 0);
      cycles(1);
      rst = 1'b0;
      cycles(1);
      check_eq("mrst_valid", m_valid, 0);
      check_eq("mrst_busy", busy, 0);
      check_eq("mrst_words_read", words_read, 0);
      check_eq("mrst_rx_cnt", rx_cnt - base, 2);
      fifo_clr = 1'b1;
      cycles(1);
      fifo_clr = 1'b0;
      cycles(2);

      // words_read wrap via a long flush burst
      base   = rx_cnt;
      stream = 1'b1;
      flush  = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         cycles(1);
         if (!busy && (rx_cnt - base == STREAM_N)) break;
      end
      check_eq("wrap_rx_cnt", rx_cnt - base, STREAM_N);
      check_eq("wrap_words_read", words_read, 1);
      check_eq("wrap_busy", busy, 0);
      flush  = 1'b0;
      stream = 1'b0;
      cycles(2);

      check_eq("rd_while_empty", rd_empty_viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_W, default 8, FIFO and stream data width.
REQ-002 Parameter CNT_W, default 7, width of FIFO occupancy counter input.
REQ-003 Parameter BURST_LEN, default 4, words per burst; legal range 1..(2**CNT_W-1).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 fifo_rd_en  output  1  read strobe to FIFO read port.
REQ-007 fifo_data_out  input  DATA_W  FIFO read data, valid the cycle after an accepted read.
REQ-008 fifo_empty  input  1  FIFO empty flag.
REQ-009 fifo_counter  input  CNT_W  FIFO occupancy.
REQ-010 flush  input  1  level; drain FIFO regardless of threshold.
REQ-011 m_data  output  DATA_W  output stream data.
REQ-012 m_valid  output  1  output stream valid.
REQ-013 m_ready  input  1  output stream ready from consumer.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 words_read  output  16  count of words delivered on the output stream, wraps at 2**16.

Function
REQ-016 Read accepted when fifo_rd_en=1 and fifo_empty=0; fifo_data_out captured into output buffer exactly one cycle later (in-flight slot).
REQ-017 fifo_rd_en never asserted while fifo_empty=1.
REQ-018 Output buffer: 2-entry in-order skid buffer; m_data = oldest entry, m_valid = buffer non-empty.
REQ-019 Output transfer occurs when m_valid=1 and m_ready=1; buffer pops oldest entry same edge.
REQ-020 Credit rule: fifo_rd_en asserted only if (occupancy + in_flight - pop_this_cycle) <= 1; buffer never overflows and no data is dropped.
REQ-021 Sustained throughput of one word per cycle when m_ready held high and FIFO non-empty.
REQ-022 m_data and m_valid held stable while m_valid=1 and m_ready=0.
REQ-023 FSM states IDLE, BURST, DRAIN.
REQ-024 IDLE -> BURST when fifo_counter >= BURST_LEN, or flush=1 and fifo_empty=0.
REQ-025 BURST: issue reads per REQ-020; track issued count 0..BURST_LEN.
REQ-026 BURST -> DRAIN when issued count reaches BURST_LEN (non-flush burst) or fifo_empty=1 with no read accepted this cycle.
REQ-027 Flush burst (flush=1 at IDLE exit) ignores BURST_LEN; ends only on fifo_empty.
REQ-028 DRAIN: no reads; -> IDLE when buffer empty and no read in flight.
REQ-029 Issued count cleared on every entry to BURST.
REQ-030 words_read increments by 1 on each output transfer; 16'hFFFF + 1 = 16'h0000.
REQ-031 flush deasserting mid-burst does not shorten a flush burst already started.

Reset
REQ-032 rst=1 at a rising edge: state=IDLE, buffer emptied, in-flight cleared, issued count=0, words_read=0.
REQ-033 During and after reset cycle: fifo_rd_en=0, m_valid=0, m_data=0, busy=0.
REQ-034 Reset mid-burst discards buffered and in-flight words; no output transfer in the reset cycle.

Structure
REQ-035 Shared package fifo_pkg holds the FSM state enumeration and default DATA_W/CNT_W constants, shared with fifo.
REQ-036 One sub-module skid_buf2 (2-entry output buffer, push/pop/occupancy); FSM and credit logic in fifo_reader.

Verification
REQ-037 Threshold: fill FIFO with 11,22,33,44, m_ready=1 -> exactly 4 reads, m_data 11,22,33,44 on consecutive cycles, busy falls, words_read=4.
REQ-038 Below threshold: 3 words in FIFO, flush=0 -> fifo_rd_en stays 0, busy=0; then flush=1 one cycle -> 3 words out in order, state returns to IDLE.
REQ-039 Backpressure: 8 words, m_ready=0 for 10 cycles -> at most 2 reads accepted, m_data stable, no loss; release -> all 8 delivered in order.
REQ-040 Empty mid-burst: 4 counted but FIFO empties after 2 reads (fifo_empty forced) -> no read while empty, BURST->DRAIN, 2 words delivered.
REQ-041 Reset mid-burst: rst after 2 of 4 words delivered -> m_valid=0, busy=0, words_read=0 next cycle.
REQ-042 Counter wrap: preload via 65537 transfers -> words_read=1.
